// File: rtl/s_mem_pkg.sv
// Shared definitions for the S-array checker and the writer loops that share its RAM port.
package s_mem_pkg;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_READ  = 2'd1,
        CHK_CHECK = 2'd2,
        CHK_DONE  = 2'd3
    } chk_state_t;

    localparam int S_DEPTH = 256;

    localparam logic MODE_IDENTITY = 1'b0;
    localparam logic MODE_PERMUTE  = 1'b1;

endpackage

// File: rtl/seen_bitmap.sv
// One flag per possible data value, used to spot duplicate entries in a permutation walk.
module seen_bitmap #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] test_idx,
    output logic              test_bit,
    input  logic              set_en,
    input  logic [DATA_W-1:0] set_idx
);

    logic [(2**DATA_W)-1:0] bits;

    // clear-all has priority so a new walk never inherits flags from the previous one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits <= '0;
        end else if (clear) begin
            bits <= '0;
        end else if (set_en) begin
            bits[set_idx] <= 1'b1;
        end
    end

    assign test_bit = bits[test_idx];

endmodule

// File: rtl/s_mem_checker.sv
// Walks the S memory through the shared RAM read port and checks identity or permutation contents.
module s_mem_checker
    import s_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic [ADDR_W-1:0] address,
    output logic              wren,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              finish,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    chk_state_t       state;
    logic [CNT_W-1:0] lat_cnt;
    logic             mode_r;
    logic             seen_bit;
    logic             q_ok;
    logic             bitmap_clear;
    logic             bitmap_set;

    assign wren = 1'b0;

    always_comb begin
        q_ok = 1'b0;
        if (mode_r == MODE_IDENTITY) begin
            q_ok = (q == address);
        end else begin
            q_ok = !seen_bit;
        end
    end

    assign bitmap_clear = (state == CHK_IDLE) && start;
    assign bitmap_set   = (state == CHK_CHECK) && (mode_r == MODE_PERMUTE) && !seen_bit;

    seen_bitmap #(
        .DATA_W (DATA_W)
    ) u_seen (
        .clk      (clk),
        .reset    (reset),
        .clear    (bitmap_clear),
        .test_idx (q),
        .test_bit (seen_bit),
        .set_en   (bitmap_set),
        .set_idx  (q)
    );

    // READ waits RD_LAT clocks for q, CHECK spends one more, giving RD_LAT+1 clocks per location
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CHK_IDLE;
            address   <= '0;
            lat_cnt   <= '0;
            mode_r    <= MODE_IDENTITY;
            busy      <= 1'b0;
            finish    <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                CHK_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        address   <= '0;
                        lat_cnt   <= CNT_LOAD;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        state     <= CHK_READ;
                    end
                end
                CHK_READ: begin
                    lat_cnt <= lat_cnt - CNT_ONE;
                    if (lat_cnt == CNT_ONE) begin
                        state <= CHK_CHECK;
                    end
                end
                CHK_CHECK: begin
                    // end of walk is the all-ones address, not an address carry-out
                    if (!q_ok) begin
                        fail_addr <= address;
                        fail_data <= q;
                        pass      <= 1'b0;
                        busy      <= 1'b0;
                        finish    <= 1'b1;
                        state     <= CHK_DONE;
                    end else if (address == LAST_ADDR) begin
                        pass   <= 1'b1;
                        busy   <= 1'b0;
                        finish <= 1'b1;
                        state  <= CHK_DONE;
                    end else begin
                        address <= address + 1'b1;
                        lat_cnt <= CNT_LOAD;
                        state   <= CHK_READ;
                    end
                end
                CHK_DONE: begin
                    if (!start) begin
                        finish <= 1'b0;
                        state  <= CHK_IDLE;
                    end
                end
                default: begin
                    state <= CHK_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s_mem_checker.sv
// Scoreboard bench for s_mem_checker: one instance at RD_LAT=1, one at RD_LAT=2, sharing a memory image.
module tb_s_mem_checker;

    typedef struct {
        logic       pass;
        logic [7:0] addr;
        logic [7:0] data;
        int         lat;
        logic [7:0] max_addr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start_v     [2];
    logic       mode_v      [2];
    logic [7:0] addr_v      [2];
    logic       wren_v      [2];
    logic [7:0] q_v         [2];
    logic       busy_v      [2];
    logic       finish_v    [2];
    logic       pass_v      [2];
    logic [7:0] fail_addr_v [2];
    logic [7:0] fail_data_v [2];

    logic [7:0] mem [256];
    logic [7:0] pipe1;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int         compared = 0;
    int         mismatched = 0;
    int         cycle = 0;
    int         start_cyc [2];
    logic [7:0] max_a     [2];
    logic       busy_prev [2];
    logic       finish_prev [2];

    s_mem_checker #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode_v[0]),
        .address(addr_v[0]), .wren(wren_v[0]), .q(q_v[0]),
        .busy(busy_v[0]), .finish(finish_v[0]), .pass(pass_v[0]),
        .fail_addr(fail_addr_v[0]), .fail_data(fail_data_v[0])
    );

    s_mem_checker #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode_v[1]),
        .address(addr_v[1]), .wren(wren_v[1]), .q(q_v[1]),
        .busy(busy_v[1]), .finish(finish_v[1]), .pass(pass_v[1]),
        .fail_addr(fail_addr_v[1]), .fail_data(fail_data_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: one and two register stages between address and q
    always @(posedge clk) begin
        cycle   <= cycle + 1;
        q_v[0]  <= mem[addr_v[0]];
        pipe1   <= mem[addr_v[1]];
        q_v[1]  <= pipe1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic p, input logic [7:0] a, input logic [7:0] d,
                                    input int lat, input logic [7:0] mx);
        exp_t e;
        e.pass = p;
        e.addr = a;
        e.data = d;
        e.lat = lat;
        e.max_addr = mx;
        return e;
    endfunction

    task automatic compareResult(input int i);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (i == 0 && exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            have = 1'b1;
        end else if (i == 1 && exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            checkOutput($sformatf("u%0d.unexpectedFinish", i), 1, 0);
            return;
        end
        checkOutput($sformatf("u%0d.pass", i), pass_v[i], e.pass);
        checkOutput($sformatf("u%0d.failAddr", i), fail_addr_v[i], e.addr);
        checkOutput($sformatf("u%0d.failData", i), fail_data_v[i], e.data);
        checkOutput($sformatf("u%0d.latency", i), cycle - start_cyc[i], e.lat);
        checkOutput($sformatf("u%0d.maxAddress", i), max_a[i], e.max_addr);
        checkOutput($sformatf("u%0d.busyAtFinish", i), busy_v[i], 0);
        checkOutput($sformatf("u%0d.wren", i), wren_v[i], 0);
    endtask

    // monitor: tracks start edge and highest driven address, compares on finish rising
    initial begin
        for (int i = 0; i < 2; i++) begin
            busy_prev[i] = 1'b0;
            finish_prev[i] = 1'b0;
            start_cyc[i] = 0;
            max_a[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (busy_v[i] && !busy_prev[i]) begin
                    start_cyc[i] = cycle;
                    max_a[i] = 8'h00;
                end
                if (busy_v[i] && addr_v[i] > max_a[i]) max_a[i] = addr_v[i];
                if (finish_v[i] && !finish_prev[i]) compareResult(i);
                busy_prev[i] = busy_v[i];
                finish_prev[i] = finish_v[i];
            end
        end
    end

    task automatic waitFinish(input int i, input int budget);
        int n;
        n = 0;
        while (!finish_v[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!finish_v[i]) checkOutput($sformatf("u%0d.finishTimeout", i), 0, 1);
    endtask

    task automatic applyStimulus(input int i, input logic m, input bit hold, input exp_t e);
        if (i == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        @(negedge clk);
        mode_v[i] = m;
        start_v[i] = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start_v[i] = 1'b0;
        end
        waitFinish(i, e.lat + 20);
        if (!hold) @(negedge clk);
    endtask

    task automatic checkResetValues(input int i, input string tag);
        checkOutput($sformatf("%s.u%0d.address", tag, i), addr_v[i], 0);
        checkOutput($sformatf("%s.u%0d.wren", tag, i), wren_v[i], 0);
        checkOutput($sformatf("%s.u%0d.busy", tag, i), busy_v[i], 0);
        checkOutput($sformatf("%s.u%0d.finish", tag, i), finish_v[i], 0);
        checkOutput($sformatf("%s.u%0d.pass", tag, i), pass_v[i], 0);
        checkOutput($sformatf("%s.u%0d.failAddr", tag, i), fail_addr_v[i], 0);
        checkOutput($sformatf("%s.u%0d.failData", tag, i), fail_data_v[i], 0);
    endtask

    task automatic fillIdentity();
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    endtask

    task automatic fillReverse();
        for (int a = 0; a < 256; a++) mem[a] = 8'(255 - a);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            mode_v[i] = 1'b0;
        end
        fillIdentity();
        repeat (3) @(negedge clk);
        checkResetValues(0, "reset");
        checkResetValues(1, "reset");
        reset = 1'b0;
        @(negedge clk);

        // identity, full pass
        applyStimulus(0, 1'b0, 1'b0, mk_exp(1'b1, 8'h00, 8'h00, 512, 8'hFF));

        // identity, corrupted entry at 0x37
        mem[8'h37] = 8'hAA;
        applyStimulus(0, 1'b0, 1'b0, mk_exp(1'b0, 8'h37, 8'hAA, 112, 8'h37));

        // reversed memory: valid permutation, but fails identity at address 0
        fillReverse();
        applyStimulus(0, 1'b1, 1'b0, mk_exp(1'b1, 8'h00, 8'h00, 512, 8'hFF));
        applyStimulus(0, 1'b0, 1'b0, mk_exp(1'b0, 8'h00, 8'hFF, 2, 8'h00));

        // duplicate 0x05 first seen at 0x10, repeated at 0xF0
        mem[8'h10] = 8'h05;
        mem[8'hF0] = 8'h05;
        applyStimulus(0, 1'b1, 1'b0, mk_exp(1'b0, 8'hF0, 8'h05, 482, 8'hF0));

        // reset in the middle of a permutation walk, then a fresh full walk
        fillReverse();
        @(negedge clk);
        mode_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (addr_v[0] != 8'h80 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midWalk.reachedAddress", addr_v[0], 8'h80);
        reset = 1'b1;
        #1;
        checkResetValues(0, "midWalk");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, mk_exp(1'b1, 8'h00, 8'h00, 512, 8'hFF));

        // start held high through DONE
        fillIdentity();
        applyStimulus(0, 1'b0, 1'b1, mk_exp(1'b1, 8'h00, 8'h00, 512, 8'hFF));
        repeat (5) @(negedge clk);
        checkOutput("hold.finishHeld", finish_v[0], 1);
        checkOutput("hold.busyLow", busy_v[0], 0);
        start_v[0] = 1'b0;
        @(negedge clk);
        checkOutput("hold.finishDropped", finish_v[0], 0);
        checkOutput("hold.passRetained", pass_v[0], 1);
        checkOutput("hold.busyIdle", busy_v[0], 0);

        // two-cycle read latency instance
        applyStimulus(1, 1'b0, 1'b0, mk_exp(1'b1, 8'h00, 8'h00, 768, 8'hFF));
        mem[8'h37] = 8'hAA;
        applyStimulus(1, 1'b0, 1'b0, mk_exp(1'b0, 8'h37, 8'hAA, 168, 8'h37));

        repeat (4) @(negedge clk);
        checkOutput("u0.pendingExpected", exp_q0.size(), 0);
        checkOutput("u1.pendingExpected", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
